huffman_dec: RTL and testbench
==============================

HUFFMAN_DEC -- requirements
Module: huffman_dec

Interface
REQ-001 SHALL have parameter NSYM, default 6, number of table entries; parameter CW, default 8, maximum codeword length in bits; parameter NPIX, default 100, symbols per image.
REQ-002 SHALL have ports, in order:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
code_valid  in  1  one-cycle pulse; sample HC1..HC6 and M1..M6 this cycle
HC1..HC6  in  8 each  codeword bits; bit 0 is the leaf-end bit
M1..M6  in  8 each  contiguous LSB-aligned mask; codeword length = popcount
bit_valid  in  1  serial code bit present
bit_in  in  1  code bit, root-first (HC[len-1] first, HC[0] last)
bit_ready  out  1  decoder accepts a bit this cycle
sym_valid  out  1  one-cycle pulse; sym_data is valid
sym_data  out  8  decoded gray value (entry j maps to value j+1, 1..6)
err  out  1  one-cycle pulse; no table match within CW bits
done  out  1  level; NPIX symbols decoded since the last table load

Function
REQ-003 SHALL implement the states IDLE (no table), LEN (compute lengths), RUN (decode), FIN (image complete).
REQ-004 In any state, code_valid SHALL latch all HC/M, clear the accumulator, bit count and symbol counter, clear done, and go to LEN on the next cycle.
REQ-005 LEN SHALL last exactly one cycle: it stores len_j = popcount(M_j) for each entry, then goes to RUN.
REQ-006 An entry with len_j = 0 SHALL never match.
REQ-007 bit_ready SHALL be 1 only in RUN; a bit is accepted when bit_valid && bit_ready.
REQ-008 On acceptance: acc <= {acc[6:0], bit_in} and n <= n+1 (n is 4 bits, range 0..8).
REQ-009 Matching SHALL use the new acc and n. Entry j matches when len_j == n and acc[n-1:0] == HC_j[n-1:0].
REQ-010 If several entries match, the lowest index SHALL win.
REQ-011 On a match: next cycle sym_valid=1 and sym_data=j+1; acc and n clear; the symbol counter increments.
REQ-012 Latency SHALL be one cycle from acceptance of the last code bit to sym_valid.
REQ-013 Back-to-back bits SHALL be accepted every cycle with no bubble after a match.
REQ-014 If n reaches CW with no match: err=1 on the next cycle, acc and n clear, the symbol counter is unchanged, and the block stays in RUN.
REQ-015 When the symbol counter reaches NPIX, the block SHALL go to FIN: bit_ready=0 and done=1 until reset or the next code_valid.
REQ-016 Bits arriving with bit_valid=1 in IDLE, LEN or FIN SHALL be ignored.
REQ-017 A code_valid arriving in the same cycle as an accepted bit SHALL win; the bit is dropped and produces no sym_valid or err.
REQ-018 The symbol counter SHALL be 7 bits and SHALL not wrap, since FIN stops intake.

Reset
REQ-019 While reset==0 at a rising clk edge, the block SHALL go to state IDLE and clear acc, n, the symbol counter, the stored table and the lengths.
REQ-020 While reset==0 at a rising clk edge, the outputs SHALL be: bit_ready=0, sym_valid=0, sym_data=0, err=0, done=0.
REQ-021 Reset mid-code SHALL discard the partial codeword; after reset, no symbol is output until a new code_valid.

Structure
REQ-022 Package huffman_pkg SHALL hold NSYM, CW, NPIX and the state enum typedef (IDLE, LEN, RUN, FIN).
REQ-023 Sub-module huffman_match SHALL compare acc and n against one entry (HC, len) and return a hit bit; it is instantiated NSYM times, and a priority select picks the lowest hit.
REQ-024 All outputs SHALL be registered.

Verification
Table T for the scenarios below:
- M = 01, 03, 07, 0F, 1F, 1F (hex)
- HC = 01, 01, 01, 01, 01, 00 (hex)
- Codes: sym1 "1", sym2 "01", sym3 "001", sym4 "0001", sym5 "00001", sym6 "00000"

REQ-025 Load T, send bit 1 -> sym_valid with sym_data=1 exactly one cycle after acceptance.
REQ-026 Load T, stream "01 00000 0001" back-to-back -> sym_data 2, 6, 4; no err; bit_ready held high.
REQ-027 Load T with M6=00, send 8 zeros -> sym5 is not reached (its code "00001" needs a 1); err pulses one cycle after the 8th bit; the next bit 1 then decodes as sym1.
REQ-028 Load T, send 100 codes of "1" -> done=1 and bit_ready=0 after the 100th sym_valid; a 101st bit is ignored.
REQ-029 After "00" is accepted, drive reset=0 for one cycle -> all outputs 0; bits ignored until code_valid; after reload, "1" decodes to 1.
REQ-030 Send code_valid in the same cycle as a bit mid-code -> no sym_valid or err; state goes to LEN then RUN; the counter is 0 and the next full code decodes correctly.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and helpers for the Huffman decoder.
package huffman_pkg;

    localparam int NSYM = 6;    // number of table entries
    localparam int CW   = 8;    // maximum codeword length in bits
    localparam int NPIX = 100;  // symbols per image
    localparam int NW   = 4;    // width of the bit counter (0..CW)
    localparam int CNTW = 7;    // width of the symbol counter

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no table loaded
        LEN  = 2'd1,  // codeword lengths being computed
        RUN  = 2'd2,  // decoding serial bits
        FIN  = 2'd3   // image complete, intake stopped
    } state_t;

    // Number of set bits in a mask; masks are contiguous so this is the code length.
    function automatic logic [NW-1:0] popcount(input logic [CW-1:0] v);
        logic [NW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CW; i++) begin
            cnt = cnt + {{(NW-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/huffman_match.sv
// Compares the shifted accumulator against one table entry.
module huffman_match
    import huffman_pkg::*;
#(
    parameter int WIDTH = CW
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [NW-1:0]    n,
    input  logic [WIDTH-1:0] hc,
    input  logic [NW-1:0]    len,
    output logic             hit
);

    // Window of the low n bits that take part in the comparison.
    logic [WIDTH-1:0] win;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_win
            assign win[gi] = (NW'(gi) < n);
        end
    endgenerate

    // A zero-length entry is an unused slot and never matches.
    assign hit = (len != '0) && (len == n) && (((acc ^ hc) & win) == '0);

endmodule

// File: rtl/huffman_dec.sv
// Serial Huffman decoder: loads a codeword table, then decodes one bit per
// cycle into gray values 1..NSYM, flagging codes that exceed CW bits.
module huffman_dec
    import huffman_pkg::*;
#(
    parameter int NSYM = huffman_pkg::NSYM,
    parameter int CW   = huffman_pkg::CW,
    parameter int NPIX = huffman_pkg::NPIX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          code_valid,
    input  logic [CW-1:0] HC1,
    input  logic [CW-1:0] HC2,
    input  logic [CW-1:0] HC3,
    input  logic [CW-1:0] HC4,
    input  logic [CW-1:0] HC5,
    input  logic [CW-1:0] HC6,
    input  logic [CW-1:0] M1,
    input  logic [CW-1:0] M2,
    input  logic [CW-1:0] M3,
    input  logic [CW-1:0] M4,
    input  logic [CW-1:0] M5,
    input  logic [CW-1:0] M6,
    input  logic          bit_valid,
    input  logic          bit_in,
    output logic          bit_ready,
    output logic          sym_valid,
    output logic [7:0]    sym_data,
    output logic          err,
    output logic          done
);

    localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;

    logic [CW-1:0]   hc_in  [NSYM];
    logic [CW-1:0]   m_in   [NSYM];
    logic [CW-1:0]   hc_reg [NSYM];
    logic [CW-1:0]   m_reg  [NSYM];
    logic [NW-1:0]   len_reg[NSYM];

    state_t          state_reg, state_next;
    logic [CW-1:0]   acc_reg, acc_next, acc_shift;
    logic [NW-1:0]   n_reg, n_next, n_inc;
    logic [CNTW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic            bit_ready_reg;
    logic            sym_valid_reg, sym_valid_next;
    logic [7:0]      sym_data_reg, sym_data_next;
    logic            err_reg, err_next;
    logic            done_reg;
    logic            load_table, load_len;

    logic [NSYM-1:0] hit;
    logic            hit_any;
    logic [IW-1:0]   hit_idx;

    assign hc_in[0] = HC1;
    assign hc_in[1] = HC2;
    assign hc_in[2] = HC3;
    assign hc_in[3] = HC4;
    assign hc_in[4] = HC5;
    assign hc_in[5] = HC6;
    assign m_in[0]  = M1;
    assign m_in[1]  = M2;
    assign m_in[2]  = M3;
    assign m_in[3]  = M4;
    assign m_in[4]  = M5;
    assign m_in[5]  = M6;

    // Matching looks at the accumulator as it will be once the current bit is in.
    assign acc_shift = {acc_reg[CW-2:0], bit_in};
    assign n_inc     = n_reg + NW'(1);
    assign cnt_inc   = cnt_reg + CNTW'(1);

    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_match
            huffman_match #(
                .WIDTH (CW)
            ) u_match (
                .acc (acc_shift),
                .n   (n_inc),
                .hc  (hc_reg[gi]),
                .len (len_reg[gi]),
                .hit (hit[gi])
            );
        end
    endgenerate

    // Priority select: scanning downwards leaves the lowest hitting index.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int j = NSYM - 1; j >= 0; j--) begin
            if (hit[j]) begin
                hit_any = 1'b1;
                hit_idx = IW'(j);
            end
        end
    end

    // Next-state and datapath update; a table load overrides any bit in flight.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        n_next         = n_reg;
        cnt_next       = cnt_reg;
        sym_valid_next = 1'b0;
        sym_data_next  = sym_data_reg;
        err_next       = 1'b0;
        load_table     = 1'b0;
        load_len       = 1'b0;
        if (code_valid) begin
            load_table = 1'b1;
            acc_next   = '0;
            n_next     = '0;
            cnt_next   = '0;
            state_next = LEN;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                LEN: begin
                    load_len   = 1'b1;
                    state_next = RUN;
                end
                RUN: begin
                    if (bit_valid) begin
                        if (hit_any) begin
                            sym_valid_next = 1'b1;
                            sym_data_next  = 8'(hit_idx) + 8'd1;
                            acc_next       = '0;
                            n_next         = '0;
                            cnt_next       = cnt_inc;
                            if (cnt_inc == CNTW'(NPIX)) begin
                                state_next = FIN;
                            end
                        end else if (n_inc == NW'(CW)) begin
                            err_next = 1'b1;
                            acc_next = '0;
                            n_next   = '0;
                        end else begin
                            acc_next = acc_shift;
                            n_next   = n_inc;
                        end
                    end
                end
                FIN:     state_next = FIN;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Accumulator, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_reg       <= '0;
            n_reg         <= '0;
            cnt_reg       <= '0;
            bit_ready_reg <= 1'b0;
            sym_valid_reg <= 1'b0;
            sym_data_reg  <= '0;
            err_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            n_reg         <= n_next;
            cnt_reg       <= cnt_next;
            bit_ready_reg <= (state_next == RUN);
            sym_valid_reg <= sym_valid_next;
            sym_data_reg  <= sym_data_next;
            err_reg       <= err_next;
            done_reg      <= (state_next == FIN);
        end
    end

    // Table storage: codes and masks on load, lengths one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < NSYM; j++) begin
                hc_reg[j]  <= '0;
                m_reg[j]   <= '0;
                len_reg[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NSYM; j++) begin
                if (load_table) begin
                    hc_reg[j] <= hc_in[j];
                    m_reg[j]  <= m_in[j];
                end
                if (load_len) begin
                    len_reg[j] <= popcount(m_reg[j]);
                end
            end
        end
    end

    assign bit_ready = bit_ready_reg;
    assign sym_valid = sym_valid_reg;
    assign sym_data  = sym_data_reg;
    assign err       = err_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_huffman_dec.sv
// Self-checking bench for huffman_dec: directed scenarios plus random tables
// and bit streams, checked every cycle against a prefix-string decoder model.
module tb_huffman_dec;

    localparam int NPIX = 100;

    logic       clk = 1'b0;
    logic       reset, code_valid, bit_valid, bit_in;
    logic [7:0] tb_hc [6];
    logic [7:0] tb_m  [6];
    logic       bit_ready, sym_valid, err, done;
    logic [7:0] sym_data;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a loaded code table and the bit prefix received so far.
    bit m_loaded, m_lenph;
    int m_cnt, m_pref, m_plen;
    int mlen [6];
    int mcode[6];
    logic       e_sv, e_err, e_rdy, e_done;
    logic [7:0] e_sd;

    int got[$];
    int err_seen;

    always #5 clk = ~clk;

    huffman_dec dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (tb_hc[0]),
        .HC2        (tb_hc[1]),
        .HC3        (tb_hc[2]),
        .HC4        (tb_hc[3]),
        .HC5        (tb_hc[4]),
        .HC6        (tb_hc[5]),
        .M1         (tb_m[0]),
        .M2         (tb_m[1]),
        .M3         (tb_m[2]),
        .M4         (tb_m[3]),
        .M5         (tb_m[4]),
        .M6         (tb_m[5]),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .err        (err),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict the outputs that follow the coming clock edge.
    task automatic model_step(input logic rs, input logic cv, input logic bv, input logic b);
        bit rdy;
        int found;
        e_sv  = 1'b0;
        e_err = 1'b0;
        if (!rs) begin
            m_loaded = 0; m_lenph = 0; m_cnt = 0; m_pref = 0; m_plen = 0;
            e_sd = 8'd0;
        end else if (cv) begin
            for (int j = 0; j < 6; j++) begin
                mlen[j] = 0;
                for (int k = 0; k < 8; k++) mlen[j] += int'(tb_m[j][k]);
                mcode[j] = int'(tb_hc[j]) % (1 << mlen[j]);
            end
            m_loaded = 1; m_lenph = 1; m_cnt = 0; m_pref = 0; m_plen = 0;
        end else begin
            rdy = m_loaded && !m_lenph && (m_cnt < NPIX);
            m_lenph = 0;
            if (bv && rdy) begin
                m_pref = m_pref * 2 + int'(b);
                m_plen++;
                found = -1;
                for (int j = 0; j < 6; j++) begin
                    if (found < 0 && mlen[j] != 0 && mlen[j] == m_plen && mcode[j] == m_pref)
                        found = j;
                end
                if (found >= 0) begin
                    e_sv = 1'b1;
                    e_sd = 8'(found + 1);
                    m_cnt++;
                    m_pref = 0; m_plen = 0;
                end else if (m_plen == 8) begin
                    e_err = 1'b1;
                    m_pref = 0; m_plen = 0;
                end
            end
        end
        e_rdy  = m_loaded && !m_lenph && (m_cnt < NPIX);
        e_done = m_loaded && !m_lenph && (m_cnt >= NPIX);
    endtask

    // One clock: drive inputs, advance model, compare registered outputs.
    task automatic cycle(input logic rs, input logic cv, input logic bv, input logic b);
        reset = rs; code_valid = cv; bit_valid = bv; bit_in = b;
        model_step(rs, cv, bv, b);
        @(posedge clk);
        #1;
        chk("sym_valid", 32'(sym_valid), 32'(e_sv));
        chk("err",       32'(err),       32'(e_err));
        chk("bit_ready", 32'(bit_ready), 32'(e_rdy));
        chk("done",      32'(done),      32'(e_done));
        if (e_sv || !rs) chk("sym_data", 32'(sym_data), 32'(e_sd));
        if (sym_valid === 1'b1) begin
            got.push_back(int'(sym_data));
            $display("t=%0t sym %0d", $time, sym_data);
        end
        if (err === 1'b1) begin
            err_seen++;
            $display("t=%0t err", $time);
        end
    endtask

    task automatic load_t(input logic [7:0] m6);
        tb_m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, m6};
        tb_hc = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++)
            cycle(1'b1, 1'b0, 1'b1, logic'(s.getc(i) == "1"));
    endtask

    task automatic clear_log();
        got.delete();
        err_seen = 0;
    endtask

    initial begin
        int r, ln;
        logic rs, cv;
        reset = 1'b0; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        tb_hc = '{default: 8'h00};
        tb_m  = '{default: 8'h00};
        err_seen = 0;

        // Reset state.
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);

        // Single-bit code decodes one cycle after acceptance.
        load_t(8'h1F);
        clear_log();
        send("1");
        chk("req025_valid", 32'(sym_valid), 32'd1);
        chk("req025_data",  32'(sym_data),  32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream.
        clear_log();
        send("01000000001");
        chk("req026_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("req026_s0", 32'(got[0]), 32'd2);
            chk("req026_s1", 32'(got[1]), 32'd6);
            chk("req026_s2", 32'(got[2]), 32'd4);
        end
        chk("req026_err", 32'(err_seen), 32'd0);

        // Overlong code raises err, then decoding resumes.
        load_t(8'h00);
        clear_log();
        send("00000000");
        chk("req027_err",   32'(err_seen),   32'd1);
        chk("req027_nosym", 32'(got.size()), 32'd0);
        send("1");
        chk("req027_after", 32'(got.size() == 1 ? got[0] : -1), 32'd1);

        // Image completion after NPIX symbols.
        load_t(8'h1F);
        clear_log();
        for (int i = 0; i < NPIX; i++) send("1");
        chk("req028_count", 32'(got.size()), 32'(NPIX));
        chk("req028_done",  32'(done),       32'd1);
        chk("req028_ready", 32'(bit_ready),  32'd0);
        send("1");
        chk("req028_ignored", 32'(got.size()), 32'(NPIX));

        // Reset mid-code.
        load_t(8'h1F);
        clear_log();
        send("00");
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        send("1111");
        chk("req029_quiet", 32'(got.size() + err_seen), 32'd0);
        load_t(8'h1F);
        send("1");
        chk("req029_reload", 32'(got.size() == 1 ? got[0] : -1), 32'd1);

        // Table load colliding with a bit mid-code.
        load_t(8'h1F);
        clear_log();
        send("00");
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("req030_quiet", 32'(got.size() + err_seen), 32'd0);
        send("001");
        chk("req030_decode", 32'(got.size() == 1 ? got[0] : -1), 32'd3);

        // Random tables and streams.
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 6; j++) begin
                ln = $urandom_range(0, 8);
                tb_m[j]  = 8'((1 << ln) - 1);
                tb_hc[j] = 8'($urandom);
            end
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            for (int c = 0; c < 300; c++) begin
                r  = $urandom_range(0, 99);
                rs = (r != 0);
                cv = (r == 1 || r == 2);
                if (cv) begin
                    for (int j = 0; j < 6; j++) begin
                        ln = $urandom_range(0, 4);
                        tb_m[j]  = 8'((1 << ln) - 1);
                        tb_hc[j] = 8'($urandom);
                    end
                end
                cycle(rs, cv, logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
